// File: rtl/secded_pkg.sv
// ----------------------------------------------------------------------------
// secded_pkg
// Shared definitions for the extended-Hamming (SECDED) decode path.
//   calc_r(data_w) : number of Hamming parity bits needed for data_w data bits
//                    (smallest r with 2^r >= data_w + r + 1)
//   is_pow2(idx)   : 1 when idx is a Hamming parity position (1, 2, 4, ...)
//   data_pos(i)    : codeword index that carries data bit i
//   syn_class_e    : classification of a received word after syndrome check
// ----------------------------------------------------------------------------
package secded_pkg;

    typedef enum logic [2:0] {
        CLEAN,
        CORR,
        DET_DBL,
        DET_RANGE,
        DET_NOCORR
    } syn_class_e;

    function automatic int calc_r(input int data_w);
        int r;
        r = 1;
        while ((1 << r) < data_w + r + 1) begin
            r++;
        end
        return r;
    endfunction

    function automatic bit is_pow2(input int idx);
        return (idx > 0) && ((idx & (idx - 1)) == 0);
    endfunction

    // Data bits occupy every non-parity position above bit 0, in ascending
    // order, so data bit 0 lands on position 3.
    function automatic int data_pos(input int i);
        int pos;
        int cnt;
        pos = 0;
        cnt = -1;
        while (cnt < i) begin
            pos++;
            if (!is_pow2(pos)) begin
                cnt++;
            end
        end
        return pos;
    endfunction

endpackage

// File: rtl/secded_syndrome.sv
// ----------------------------------------------------------------------------
// secded_syndrome
// Combinational syndrome generator for an extended-Hamming codeword.
//   code_word [CW-1:0] : received codeword (bit 0 = overall parity)
//   syn       [R-1:0]  : XOR of the indices of all set bits in positions 1..CW-1
//   parity             : XOR of all CW bits (1 = odd number of bit errors)
// Kept separate so the encoder self-check path can reuse it.
// ----------------------------------------------------------------------------
module secded_syndrome #(
    parameter int CW = 12,
    parameter int R  = 4
) (
    input  logic [CW-1:0] code_word,
    output logic [R-1:0]  syn,
    output logic          parity
);

    // A clean codeword has its set-bit indices cancel out, so any residue is
    // the position of a single flipped bit (or garbage for multiple flips).
    always_comb begin
        syn = '0;
        for (int i = 1; i < CW; i++) begin
            if (code_word[i]) begin
                syn = syn ^ R'(i);
            end
        end
    end

    assign parity = ^code_word;

endmodule

// File: rtl/secded_pipe_decoder.sv
// ----------------------------------------------------------------------------
// secded_pipe_decoder
// Two-stage pipelined SECDED decoder with valid/ready streaming on both sides.
//   i_Clk, i_Rst_n      : clock (rising edge), async active-low reset
//   i_Valid / o_Ready   : upstream handshake, i_CodeWord [CW-1:0], i_CorrEn
//   o_Valid / i_Ready   : downstream handshake
//   o_DecodWord         : decoded data [DATA_W-1:0]
//   o_Syndrome          : {hamming syndrome, overall parity flag} [R:0]
//   o_ErrorC / o_ErrorD : single error corrected / error detected, not fixed
//   i_ClrCnt            : synchronous clear of counters and syndrome log
//   o_CntC / o_CntD     : saturating counts of corrected / detected words
//   o_LastSyn           : syndrome of the last delivered word with nonzero syndrome
// Stage 1 computes the syndrome; stage 2 classifies, corrects and extracts data.
// ----------------------------------------------------------------------------
module secded_pipe_decoder
    import secded_pkg::*;
#(
    parameter int  DATA_W = 7,
    parameter int  CNT_W  = 16,
    localparam int R      = calc_r(DATA_W),
    localparam int CW     = DATA_W + R + 1
) (
    input  logic              i_Clk,
    input  logic              i_Rst_n,
    input  logic              i_Valid,
    output logic              o_Ready,
    input  logic [CW-1:0]     i_CodeWord,
    input  logic              i_CorrEn,
    output logic              o_Valid,
    input  logic              i_Ready,
    output logic [DATA_W-1:0] o_DecodWord,
    output logic [R:0]        o_Syndrome,
    output logic              o_ErrorC,
    output logic              o_ErrorD,
    input  logic              i_ClrCnt,
    output logic [CNT_W-1:0]  o_CntC,
    output logic [CNT_W-1:0]  o_CntD,
    output logic [R:0]        o_LastSyn
);

    localparam logic [R:0] CW_EXT = (R + 1)'(CW);

    logic              v1;
    logic              v2;
    logic              en1;
    logic              en2;
    logic              ce1;
    logic              p1;
    logic              p_calc;
    logic [R-1:0]      s1;
    logic [R-1:0]      s_calc;
    logic [DATA_W-1:0] d_in;
    logic [DATA_W-1:0] d1;
    logic [DATA_W-1:0] d_fix;
    logic              do_flip;
    logic              xfer;
    syn_class_e        cls;

    // Each stage may load when it is empty or its contents move on this cycle.
    assign en2     = !v2 || i_Ready;
    assign en1     = !v1 || en2;
    assign o_Ready = en1;
    assign o_Valid = v2;
    assign xfer    = v2 && i_Ready;

    secded_syndrome #(
        .CW(CW),
        .R (R)
    ) u_syndrome (
        .code_word(i_CodeWord),
        .syn      (s_calc),
        .parity   (p_calc)
    );

    // Only the data positions need to travel down the pipe: a flip landing on
    // a parity position never changes the delivered data.
    for (genvar gi = 0; gi < DATA_W; gi++) begin : g_data
        localparam int POS = data_pos(gi);
        assign d_in[gi]  = i_CodeWord[POS];
        assign d_fix[gi] = d1[gi] ^ (do_flip && (s1 == R'(POS)));
    end

    // Stage 1 captures the data field, correction mode and syndrome.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            v1  <= 1'b0;
            d1  <= '0;
            ce1 <= 1'b0;
            s1  <= '0;
            p1  <= 1'b0;
        end else if (en1) begin
            v1 <= i_Valid;
            if (i_Valid) begin
                d1  <= d_in;
                ce1 <= i_CorrEn;
                s1  <= s_calc;
                p1  <= p_calc;
            end
        end
    end

    // Odd parity means an odd number of flips; only an in-range syndrome can
    // name a real bit to repair. Even parity with a residue is a double error.
    always_comb begin
        cls = CLEAN;
        if (p1) begin
            if ({1'b0, s1} >= CW_EXT) begin
                cls = DET_RANGE;
            end else if (ce1) begin
                cls = CORR;
            end else begin
                cls = DET_NOCORR;
            end
        end else if (s1 != '0) begin
            cls = DET_DBL;
        end
    end

    assign do_flip = (cls == CORR);

    // Stage 2 holds its result while the consumer stalls, so the outputs stay
    // stable until they are taken.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            v2          <= 1'b0;
            o_DecodWord <= '0;
            o_Syndrome  <= '0;
            o_ErrorC    <= 1'b0;
            o_ErrorD    <= 1'b0;
        end else if (en2) begin
            v2 <= v1;
            if (v1) begin
                o_DecodWord <= d_fix;
                o_Syndrome  <= {s1, p1};
                o_ErrorC    <= (cls == CORR);
                o_ErrorD    <= (cls == DET_DBL) || (cls == DET_RANGE) ||
                               (cls == DET_NOCORR);
            end
        end
    end

    // Statistics follow delivered words only; a clear in the same cycle as a
    // delivery discards that delivery's contribution.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            o_CntC    <= '0;
            o_CntD    <= '0;
            o_LastSyn <= '0;
        end else if (i_ClrCnt) begin
            o_CntC    <= '0;
            o_CntD    <= '0;
            o_LastSyn <= '0;
        end else if (xfer) begin
            if (o_ErrorC && (o_CntC != '1)) begin
                o_CntC <= o_CntC + CNT_W'(1);
            end
            if (o_ErrorD && (o_CntD != '1)) begin
                o_CntD <= o_CntD + CNT_W'(1);
            end
            if (o_Syndrome != '0) begin
                o_LastSyn <= o_Syndrome;
            end
        end
    end

endmodule

// File: tb/tb_secded_pipe_decoder.sv
// ----------------------------------------------------------------------------
// tb_secded_pipe_decoder
// Drives random and directed codewords into two decoder instances (16-bit and
// 2-bit counters) that share all inputs. Expected results come from a model
// that encodes data, injects known bit flips and classifies from the flip
// positions. A monitor process pops expectations as outputs are delivered.
// ----------------------------------------------------------------------------
module tb_secded_pipe_decoder;

    localparam int DATA_W = 7;
    localparam int CW     = 12;
    localparam int SW     = 5;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic [SW-1:0]     syn;
        logic              err_c;
        logic              err_d;
        int                stamp;
    } exp_t;

    logic              i_Clk = 1'b0;
    logic              i_Rst_n;
    logic              i_Valid;
    logic              o_Ready;
    logic [CW-1:0]     i_CodeWord;
    logic              i_CorrEn;
    logic              o_Valid;
    logic              i_Ready;
    logic [DATA_W-1:0] o_DecodWord;
    logic [SW-1:0]     o_Syndrome;
    logic              o_ErrorC;
    logic              o_ErrorD;
    logic              i_ClrCnt;
    logic [15:0]       o_CntC;
    logic [15:0]       o_CntD;
    logic [SW-1:0]     o_LastSyn;

    logic              sat_Ready;
    logic              sat_Valid;
    logic [DATA_W-1:0] sat_DecodWord;
    logic [SW-1:0]     sat_Syndrome;
    logic              sat_ErrorC;
    logic              sat_ErrorD;
    logic [1:0]        sat_CntC;
    logic [1:0]        sat_CntD;
    logic [SW-1:0]     sat_LastSyn;

    int   errors = 0;
    int   checks = 0;
    int   mon_cyc = 0;
    int   hold_cycles = 0;
    bit   rnd_ready = 1'b0;
    exp_t exp_q[$];

    int   m_cnt_c = 0;
    int   m_cnt_d = 0;
    int   m_sat_c = 0;
    int   m_sat_d = 0;
    logic [SW-1:0] m_last = '0;

    always #5 i_Clk = ~i_Clk;

    secded_pipe_decoder #(.DATA_W(7), .CNT_W(16)) dut (
        .i_Clk(i_Clk), .i_Rst_n(i_Rst_n), .i_Valid(i_Valid), .o_Ready(o_Ready),
        .i_CodeWord(i_CodeWord), .i_CorrEn(i_CorrEn), .o_Valid(o_Valid),
        .i_Ready(i_Ready), .o_DecodWord(o_DecodWord), .o_Syndrome(o_Syndrome),
        .o_ErrorC(o_ErrorC), .o_ErrorD(o_ErrorD), .i_ClrCnt(i_ClrCnt),
        .o_CntC(o_CntC), .o_CntD(o_CntD), .o_LastSyn(o_LastSyn)
    );

    secded_pipe_decoder #(.DATA_W(7), .CNT_W(2)) dut_sat (
        .i_Clk(i_Clk), .i_Rst_n(i_Rst_n), .i_Valid(i_Valid), .o_Ready(sat_Ready),
        .i_CodeWord(i_CodeWord), .i_CorrEn(i_CorrEn), .o_Valid(sat_Valid),
        .i_Ready(i_Ready), .o_DecodWord(sat_DecodWord), .o_Syndrome(sat_Syndrome),
        .o_ErrorC(sat_ErrorC), .o_ErrorD(sat_ErrorD), .i_ClrCnt(i_ClrCnt),
        .o_CntC(sat_CntC), .o_CntD(sat_CntD), .o_LastSyn(sat_LastSyn)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic bit pow2(input int idx);
        return (idx > 0) && ((idx & (idx - 1)) == 0);
    endfunction

    // Reference encoder: data into non-power-of-two slots, then parity bits
    // chosen so the indices of all set bits cancel, then overall even parity.
    function automatic logic [CW-1:0] encode(input logic [DATA_W-1:0] d);
        logic [CW-1:0] w;
        int di;
        int h;
        w  = '0;
        di = 0;
        h  = 0;
        for (int pos = 1; pos < CW; pos++) begin
            if (!pow2(pos)) begin
                w[pos] = d[di];
                di++;
            end
        end
        for (int pos = 1; pos < CW; pos++) begin
            if (w[pos]) h = h ^ pos;
        end
        for (int k = 0; (1 << k) < CW; k++) begin
            if (h[k]) w[1 << k] = 1'b1;
        end
        w[0] = ^w;
        return w;
    endfunction

    function automatic logic [DATA_W-1:0] extract(input logic [CW-1:0] w);
        logic [DATA_W-1:0] d;
        int di;
        d  = '0;
        di = 0;
        for (int pos = 1; pos < CW; pos++) begin
            if (!pow2(pos)) begin
                d[di] = w[pos];
                di++;
            end
        end
        return d;
    endfunction

    function automatic exp_t mkExp(input logic [DATA_W-1:0] d, input logic [SW-1:0] s,
                                   input logic c, input logic e);
        exp_t r;
        r.data  = d;
        r.syn   = s;
        r.err_c = c;
        r.err_d = e;
        r.stamp = 0;
        return r;
    endfunction

    // Builds a corrupted codeword from known flip positions; the syndrome is
    // the XOR of those positions and the parity flag is the flip count parity.
    task automatic buildWord(input logic [DATA_W-1:0] d, input int f0, input int f1,
                             input int f2, input int nf, input bit corr,
                             output logic [CW-1:0] word, output exp_t e);
        int f[3];
        int s;
        int p;
        logic [CW-1:0] fixed;
        f[0] = f0; f[1] = f1; f[2] = f2;
        word = encode(d);
        s = 0;
        for (int j = 0; j < nf; j++) begin
            word[f[j]] = ~word[f[j]];
            s = s ^ f[j];
        end
        p = nf % 2;
        fixed = word;
        e.err_c = 1'b0;
        e.err_d = 1'b0;
        if (p == 1) begin
            if (s < CW && corr) begin
                fixed[s] = ~fixed[s];
                e.err_c = 1'b1;
            end else begin
                e.err_d = 1'b1;
            end
        end else if (s != 0) begin
            e.err_d = 1'b1;
        end
        e.data  = extract(fixed);
        e.syn   = SW'((s << 1) | p);
        e.stamp = 0;
    endtask

    // Presents one word and holds it until accepted; the expectation is
    // queued at the accepting edge.
    task automatic applyStimulus(input logic [CW-1:0] word, input bit corr,
                                 input bit clr, input exp_t e);
        bit done;
        int tries;
        i_Valid    = 1'b1;
        i_CodeWord = word;
        i_CorrEn   = corr;
        i_ClrCnt   = clr;
        done  = 1'b0;
        tries = 0;
        while (!done) begin
            @(negedge i_Clk);
            done = o_Ready;
            @(posedge i_Clk);
            if (done) begin
                e.stamp = mon_cyc;
                exp_q.push_back(e);
            end else begin
                tries++;
                if (tries > 100) begin
                    checkOutput("accept_timeout", 32'd0, 32'd1);
                    done = 1'b1;
                end
            end
            #1;
        end
        i_Valid  = 1'b0;
        i_ClrCnt = 1'b0;
    endtask

    task automatic idleCycles(input int n, input bit clr);
        i_Valid  = 1'b0;
        i_ClrCnt = clr;
        repeat (n) begin
            @(posedge i_Clk);
            #1;
        end
        i_ClrCnt = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        i_Valid = 1'b0;
        while (exp_q.size() > 0 && n < 300) begin
            @(posedge i_Clk);
            #1;
            n++;
        end
        checkOutput("drain_empty", exp_q.size(), 0);
    endtask

    task automatic sendRandom(input bit allow_clr);
        logic [DATA_W-1:0] d;
        logic [CW-1:0] w;
        exp_t e;
        int f[3];
        int nf;
        int r;
        int cand;
        bit dup;
        bit corr;
        d  = DATA_W'($urandom);
        r  = $urandom_range(0, 9);
        nf = (r < 4) ? 0 : (r < 7) ? 1 : (r < 9) ? 2 : 3;
        for (int j = 0; j < 3; j++) f[j] = 0;
        for (int j = 0; j < nf; j++) begin
            dup = 1'b1;
            cand = 0;
            while (dup) begin
                cand = $urandom_range(0, CW - 1);
                dup = 1'b0;
                for (int k = 0; k < j; k++) if (f[k] == cand) dup = 1'b1;
            end
            f[j] = cand;
        end
        corr = ($urandom_range(0, 3) != 0);
        buildWord(d, f[0], f[1], f[2], nf, corr, w, e);
        applyStimulus(w, corr, allow_clr && ($urandom_range(0, 19) == 0), e);
    endtask

    task automatic resetCheck();
        checkOutput("rst_o_Valid", o_Valid, 0);
        checkOutput("rst_o_DecodWord", o_DecodWord, 0);
        checkOutput("rst_o_Syndrome", o_Syndrome, 0);
        checkOutput("rst_o_ErrorC", o_ErrorC, 0);
        checkOutput("rst_o_ErrorD", o_ErrorD, 0);
        checkOutput("rst_o_CntC", o_CntC, 0);
        checkOutput("rst_o_CntD", o_CntD, 0);
        checkOutput("rst_o_LastSyn", o_LastSyn, 0);
        checkOutput("rst_sat_Valid", sat_Valid, 0);
        checkOutput("rst_sat_CntC", sat_CntC, 0);
    endtask

    // Downstream ready: scripted stall window, random, or always ready.
    initial begin
        i_Ready = 1'b1;
        forever begin
            @(posedge i_Clk);
            #1;
            if (hold_cycles > 0) begin
                i_Ready = 1'b0;
                hold_cycles--;
            end else if (rnd_ready) begin
                i_Ready = ($urandom_range(0, 3) != 0);
            end else begin
                i_Ready = 1'b1;
            end
        end
    end

    // Monitor: the oldest queued word must be on the output once it has had
    // two edges to travel; backpressure with two words queued blocks input.
    initial begin
        exp_t e;
        bit exp_valid;
        forever begin
            @(negedge i_Clk);
            mon_cyc++;
            if (!i_Rst_n) begin
                m_cnt_c = 0; m_cnt_d = 0; m_sat_c = 0; m_sat_d = 0; m_last = '0;
            end else begin
                exp_valid = (exp_q.size() > 0) && (mon_cyc - exp_q[0].stamp >= 2);
                checkOutput("o_Valid", o_Valid, exp_valid);
                checkOutput("sat_Valid", sat_Valid, exp_valid);
                checkOutput("o_Ready", o_Ready, !(exp_q.size() >= 2 && !i_Ready));
                checkOutput("sat_Ready", sat_Ready, !(exp_q.size() >= 2 && !i_Ready));
                checkOutput("o_CntC", o_CntC, m_cnt_c);
                checkOutput("o_CntD", o_CntD, m_cnt_d);
                checkOutput("o_LastSyn", o_LastSyn, m_last);
                checkOutput("sat_CntC", sat_CntC, m_sat_c);
                checkOutput("sat_CntD", sat_CntD, m_sat_d);
                checkOutput("sat_LastSyn", sat_LastSyn, m_last);
                if (exp_valid) begin
                    e = exp_q[0];
                    checkOutput("o_DecodWord", o_DecodWord, e.data);
                    checkOutput("o_Syndrome", o_Syndrome, e.syn);
                    checkOutput("o_ErrorC", o_ErrorC, e.err_c);
                    checkOutput("o_ErrorD", o_ErrorD, e.err_d);
                    checkOutput("sat_DecodWord", sat_DecodWord, e.data);
                    checkOutput("sat_Syndrome", sat_Syndrome, e.syn);
                    checkOutput("sat_ErrorC", sat_ErrorC, e.err_c);
                    checkOutput("sat_ErrorD", sat_ErrorD, e.err_d);
                    if (i_Ready) begin
                        void'(exp_q.pop_front());
                        if (e.err_c) begin
                            if (m_cnt_c < 65535) m_cnt_c++;
                            if (m_sat_c < 3) m_sat_c++;
                        end
                        if (e.err_d) begin
                            if (m_cnt_d < 65535) m_cnt_d++;
                            if (m_sat_d < 3) m_sat_d++;
                        end
                        if (e.syn != '0) m_last = e.syn;
                    end
                end
                if (i_ClrCnt) begin
                    m_cnt_c = 0; m_cnt_d = 0; m_sat_c = 0; m_sat_d = 0; m_last = '0;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        i_Rst_n    = 1'b0;
        i_Valid    = 1'b0;
        i_CodeWord = '0;
        i_CorrEn   = 1'b1;
        i_ClrCnt   = 1'b0;
        repeat (3) @(posedge i_Clk);
        #1;
        resetCheck();
        @(negedge i_Clk);
        #1 i_Rst_n = 1'b1;
        @(posedge i_Clk);
        #1;

        // Directed words around data 7'h59 (clean codeword 12'hA9C).
        applyStimulus(12'hA9C, 1'b1, 1'b0, mkExp(7'h59, 5'h00, 1'b0, 1'b0));
        applyStimulus(12'hADC, 1'b1, 1'b0, mkExp(7'h59, 5'h0D, 1'b1, 1'b0));
        applyStimulus(12'hA9D, 1'b1, 1'b0, mkExp(7'h59, 5'h01, 1'b1, 1'b0));
        applyStimulus(12'hAD4, 1'b1, 1'b0, mkExp(7'h5C, 5'h0A, 1'b0, 1'b1));
        // bits 1, 4 and 8 flipped: s = 13, outside the 12-bit codeword
        applyStimulus(12'hB8E, 1'b1, 1'b0, mkExp(7'h59, 5'h1B, 1'b0, 1'b1));
        applyStimulus(12'hADC, 1'b0, 1'b0, mkExp(7'h5D, 5'h0D, 1'b0, 1'b1));
        drain();
        checkOutput("dir_CntC", o_CntC, 2);
        checkOutput("dir_CntD", o_CntD, 3);
        checkOutput("dir_LastSyn", o_LastSyn, 5'h0D);

        // Clear arriving in the same cycle as a corrected delivery.
        applyStimulus(12'hADC, 1'b1, 1'b0, mkExp(7'h59, 5'h0D, 1'b1, 1'b0));
        idleCycles(1, 1'b0);
        idleCycles(1, 1'b1);
        checkOutput("clr_wins_CntC", o_CntC, 0);
        checkOutput("clr_wins_sat", sat_CntC, 0);
        drain();

        // Saturation of the 2-bit counter.
        repeat (4) applyStimulus(12'hADC, 1'b1, 1'b0, mkExp(7'h59, 5'h0D, 1'b1, 1'b0));
        drain();
        checkOutput("sat_after4", sat_CntC, 3);
        checkOutput("cnt_after4", o_CntC, 4);
        applyStimulus(12'hA9D, 1'b1, 1'b0, mkExp(7'h59, 5'h01, 1'b1, 1'b0));
        drain();
        checkOutput("sat_after5", sat_CntC, 3);
        checkOutput("cnt_after5", o_CntC, 5);

        // Five back-to-back words with a three-cycle stall in the middle.
        sendRandom(1'b0);
        sendRandom(1'b0);
        hold_cycles = 3;
        sendRandom(1'b0);
        sendRandom(1'b0);
        sendRandom(1'b0);
        drain();

        // Random traffic with random backpressure and occasional clears.
        rnd_ready = 1'b1;
        for (int n = 0; n < 300; n++) begin
            sendRandom(1'b1);
            if ($urandom_range(0, 7) == 0) idleCycles(1, 1'b0);
        end
        drain();
        rnd_ready = 1'b0;

        // Reset with words in flight.
        for (int n = 0; n < 3; n++) sendRandom(1'b0);
        #2 i_Rst_n = 1'b0;
        #1;
        resetCheck();
        exp_q.delete();
        i_Valid = 1'b0;
        repeat (2) @(posedge i_Clk);
        @(negedge i_Clk);
        #1 i_Rst_n = 1'b1;
        @(posedge i_Clk);
        #1;

        applyStimulus(12'hA9C, 1'b1, 1'b0, mkExp(7'h59, 5'h00, 1'b0, 1'b0));
        applyStimulus(12'hADC, 1'b1, 1'b0, mkExp(7'h59, 5'h0D, 1'b1, 1'b0));
        drain();
        checkOutput("post_rst_CntC", o_CntC, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
